unpack_float64: RTL and testbench

Iterative unpacker and normalizer for IEEE-754 binary64 operands, the inverse of the round-and-pack stage in the DF MUL datapath. It accepts a packed 64-bit float and classifies it. It returns sign, a 13-bit signed exponent and a significand with the implicit bit explicit at bit 52. Subnormals are normalized one bit per cycle. The block sits at the operand-input end of the multiplier, ahead of significand multiplication, and uses the same start/done/idle/ready block handshake and exception-flag pass-through as the packing stage.

---
 rtl/unpack_float64.sv | 140 ++++++++++++++
 tb/tb_unpack_float64.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/unpack_float64.sv
// ============================================================================
//  Module      : unpack_float64
//  Description : IEEE-754 binary64 operand unpacker with iterative subnormal
//                normalization and exception-flag pass-through.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unpack_float64 (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [31:0] float_exception_flag_i,
    output logic [31:0] float_exception_flag_o,
    output logic        float_exception_flag_o_ap_vld,
    output logic        zSign,
    output logic [12:0] zExp,
    output logic [63:0] zSig,
    output logic [2:0]  zClass
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        NORM = 3'b010,
        DONE = 3'b100
    } state_t;

    localparam logic [2:0]  CLASS_ZERO   = 3'd0;
    localparam logic [2:0]  CLASS_NORMAL = 3'd1;
    localparam logic [2:0]  CLASS_SUBNRM = 3'd2;
    localparam logic [2:0]  CLASS_INF    = 3'd3;
    localparam logic [2:0]  CLASS_QNAN   = 3'd4;
    localparam logic [2:0]  CLASS_SNAN   = 3'd5;
    localparam logic [31:0] FLAG_INVALID = 32'd16;

    state_t      state, state_next;
    logic        sign_next;
    logic [12:0] exp_next;
    logic [63:0] sig_next;
    logic [2:0]  class_next;
    logic [10:0] exp_field;
    logic [51:0] frac_field;
    logic [63:0] sig_shifted;

    assign exp_field   = a[62:52];
    assign frac_field  = a[51:0];
    assign sig_shifted = zSig << 1;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state  <= IDLE;
            zSign  <= 1'b0;
            zExp   <= 13'd0;
            zSig   <= 64'd0;
            zClass <= 3'd0;
        end else begin
            state  <= state_next;
            zSign  <= sign_next;
            zExp   <= exp_next;
            zSig   <= sig_next;
            zClass <= class_next;
        end
    end

    always_comb begin
        state_next                    = state;
        sign_next                     = zSign;
        exp_next                      = zExp;
        sig_next                      = zSig;
        class_next                    = zClass;
        ap_done                       = 1'b0;
        ap_idle                       = 1'b0;
        float_exception_flag_o        = float_exception_flag_i;
        float_exception_flag_o_ap_vld = 1'b0;

        case (state)
            IDLE: begin
                ap_idle = ~ap_start;
                if (ap_start) begin
                    sign_next  = a[63];
                    state_next = DONE;
                    if (exp_field == 11'd0) begin
                        if (frac_field == 52'd0) begin
                            exp_next   = 13'd0;
                            sig_next   = 64'd0;
                            class_next = CLASS_ZERO;
                        end else begin
                            // Start at the minimum normal exponent and let
                            // NORM walk it down one per shift.
                            exp_next   = 13'd1;
                            sig_next   = {12'd0, frac_field};
                            class_next = CLASS_SUBNRM;
                            state_next = NORM;
                        end
                    end else if (exp_field == 11'h7FF) begin
                        exp_next = 13'h07FF;
                        if (frac_field == 52'd0) begin
                            sig_next   = 64'd0;
                            class_next = CLASS_INF;
                        end else begin
                            sig_next   = {12'd0, frac_field};
                            class_next = frac_field[51] ? CLASS_QNAN : CLASS_SNAN;
                        end
                    end else begin
                        exp_next   = {2'b00, exp_field};
                        sig_next   = {11'd0, 1'b1, frac_field};
                        class_next = CLASS_NORMAL;
                    end
                end
            end
            NORM: begin
                sig_next = sig_shifted;
                exp_next = zExp - 13'd1;
                if (sig_shifted[52]) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ap_done    = 1'b1;
                state_next = IDLE;
                if (zClass == CLASS_SNAN) begin
                    float_exception_flag_o        = float_exception_flag_i | FLAG_INVALID;
                    float_exception_flag_o_ap_vld = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ap_ready = ap_done;

endmodule

`default_nettype wire

// File: tb/tb_unpack_float64.sv
// ============================================================================
//  Module      : tb_unpack_float64
//  Description : Self-checking bench for unpack_float64 against a behavioural
//                classification/normalization model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unpack_float64;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [63:0] a = 64'd0;
    logic [31:0] flag_i = 32'd0;
    logic [31:0] flag_o;
    logic        flag_vld;
    logic        zSign;
    logic [12:0] zExp;
    logic [63:0] zSig;
    logic [2:0]  zClass;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    unpack_float64 dut (
        .ap_clk                        (ap_clk),
        .ap_rst                        (ap_rst),
        .ap_start                      (ap_start),
        .ap_done                       (ap_done),
        .ap_idle                       (ap_idle),
        .ap_ready                      (ap_ready),
        .a                             (a),
        .float_exception_flag_i        (flag_i),
        .float_exception_flag_o        (flag_o),
        .float_exception_flag_o_ap_vld (flag_vld),
        .zSign                         (zSign),
        .zExp                          (zExp),
        .zSig                          (zSig),
        .zClass                        (zClass)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: derive results from the binary64 field rules with integers.
    function automatic void model(input logic [63:0] av, output logic sgn,
                                  output logic [12:0] ex, output logic [63:0] sg,
                                  output logic [2:0] cl, output int lat);
        int e;
        longint unsigned f;
        int p;
        int s;
        e   = int'(av[62:52]);
        f   = longint'(av[51:0]);
        sgn = av[63];
        lat = 1;
        if (e == 0 && f == 0) begin
            ex = 13'd0; sg = 64'd0; cl = 3'd0;
        end else if (e == 0) begin
            p = 0;
            for (int i = 0; i < 52; i++) if (((f >> i) & 1) == 1) p = i;
            s   = 52 - p;
            ex  = 13'(1 - s);
            sg  = f << s;
            cl  = 3'd2;
            lat = s + 1;
        end else if (e == 2047) begin
            ex = 13'd2047;
            sg = f;
            if (f == 0) cl = 3'd3;
            else if (((f >> 51) & 1) == 1) cl = 3'd4;
            else cl = 3'd5;
        end else begin
            ex = 13'(e);
            sg = (64'd1 << 52) + f;
            cl = 3'd1;
        end
    endfunction

    task automatic run_op(input logic [63:0] av, input logic [31:0] fl);
        logic        m_sgn;
        logic [12:0] m_exp;
        logic [63:0] m_sig;
        logic [2:0]  m_cl;
        int          m_lat;
        int          cyc;
        model(av, m_sgn, m_exp, m_sig, m_cl, m_lat);
        @(negedge ap_clk);
        a = av; flag_i = fl; ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        a = {$urandom, $urandom};
        cyc = 1;
        @(negedge ap_clk);
        while (!ap_done && cyc < 60) begin
            @(negedge ap_clk);
            cyc++;
        end
        check("latency",  64'(cyc), 64'(m_lat));
        check("done",     64'(ap_done), 64'd1);
        check("ready",    64'(ap_ready), 64'd1);
        check("zSign",    64'(zSign), 64'(m_sgn));
        check("zExp",     64'(zExp), 64'(m_exp));
        check("zSig",     zSig, m_sig);
        check("zClass",   64'(zClass), 64'(m_cl));
        check("flag_o",   64'(flag_o), 64'((m_cl == 3'd5) ? (fl | 32'd16) : fl));
        check("flag_vld", 64'(flag_vld), 64'(m_cl == 3'd5));
        @(negedge ap_clk);
        check("done_pulse", 64'(ap_done), 64'd0);
        check("vld_pulse",  64'(flag_vld), 64'd0);
        check("flag_pass",  64'(flag_o), 64'(fl));
        check("zSig_hold",  zSig, m_sig);
        check("idle_after", 64'(ap_idle), 64'd1);
    endtask

    initial begin
        logic [63:0] rv;
        logic        saw_done;
        int          sel;

        // Asynchronous reset, observed before any clock edge
        #1 ap_rst = 1'b1;
        #1;
        check("rst_zSign",  64'(zSign), 64'd0);
        check("rst_zExp",   64'(zExp), 64'd0);
        check("rst_zSig",   zSig, 64'd0);
        check("rst_zClass", 64'(zClass), 64'd0);
        check("rst_done",   64'(ap_done), 64'd0);
        check("rst_vld",    64'(flag_vld), 64'd0);
        check("rst_idle",   64'(ap_idle), 64'd1);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // Directed operands
        run_op(64'h3FF0000000000000, 32'h0);
        run_op(64'h0000000000000001, 32'h0);
        run_op(64'h8008000000000000, 32'h0);
        run_op(64'h7FF0000000000001, 32'h1);
        run_op(64'h7FF8000000000000, 32'h1);
        run_op(64'hFFF0000000000000, 32'h0);
        run_op(64'h8000000000000000, 32'h0);
        run_op(64'h7FEFFFFFFFFFFFFF, 32'h0);
        run_op(64'h000FFFFFFFFFFFFF, 32'h0);

        // Reset in the middle of NORM
        @(negedge ap_clk);
        a = 64'h0000000000000001; ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        #2 ap_rst = 1'b1;
        #1;
        check("mid_rst_zSig",  zSig, 64'd0);
        check("mid_rst_zExp",  64'(zExp), 64'd0);
        check("mid_rst_done",  64'(ap_done), 64'd0);
        check("mid_rst_idle",  64'(ap_idle), 64'd1);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        saw_done = 1'b0;
        repeat (60) begin
            @(negedge ap_clk);
            if (ap_done || flag_vld) saw_done = 1'b1;
        end
        check("mid_rst_no_done", 64'(saw_done), 64'd0);

        // Back-to-back with ap_start held high
        @(negedge ap_clk);
        a = 64'h4000000000000000; ap_start = 1'b1;
        @(posedge ap_clk);
        #1 a = 64'h3FF0000000000000;
        @(negedge ap_clk);
        check("b2b_done1", 64'(ap_done), 64'd1);
        check("b2b_zExp1", 64'(zExp), 64'h0400);
        @(negedge ap_clk);
        check("b2b_bubble_done", 64'(ap_done), 64'd0);
        check("b2b_bubble_idle", 64'(ap_idle), 64'd0);
        check("b2b_hold_zExp",   64'(zExp), 64'h0400);
        @(negedge ap_clk);
        ap_start = 1'b0;
        check("b2b_done2", 64'(ap_done), 64'd1);
        check("b2b_zExp2", 64'(zExp), 64'h03FF);
        @(negedge ap_clk);

        // Randomized operands covering all exponent regions
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 3);
            rv  = {$urandom, $urandom};
            case (sel)
                0: begin
                    rv[62:52] = 11'd0;
                    rv[51:0]  = rv[51:0] >> $urandom_range(0, 51);
                end
                1: rv[62:52] = 11'h7FF;
                2: begin
                    rv[62:52] = 11'h7FF;
                    rv[51:0]  = rv[51:0] >> $urandom_range(40, 52);
                end
                default: ;
            endcase
            run_op(rv, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
